// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg : shared FSM state type, limits and byte-merge helper    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WAIT_STATES = 15;
    localparam int WCNT_W          = 4;
    localparam int MAX_DATA_W      = 512;

    // Callers zero-extend into the widest supported word and truncate the result.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0]   old_word,
        input logic [MAX_DATA_W-1:0]   new_word,
        input logic [MAX_DATA_W/8-1:0] be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_DATA_W/8; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_array : storage with byte-merged write and registered read;  |
// | DMEM_PARITY_EN adds one even-parity bit per word. Rev 1.0         |
// +------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4112,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                access,
    input  logic                wr,
    input  logic                in_range,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                par_err
);

    // Only word 1 has defined start-up content; everything else is unknown.
    logic [DATA_W-1:0] mem [DEPTH] = '{1: DATA_W'(1), default: 'x};
    logic [DATA_W-1:0] w_merged;

    always_comb begin
        w_merged = DATA_W'(byte_merge(MAX_DATA_W'(mem[idx]), MAX_DATA_W'(wr_data),
                                      (MAX_DATA_W/8)'(byte_en)));
    end

`ifdef DMEM_PARITY_EN
    logic par [DEPTH] = '{1: 1'b1, default: 1'bx};

    always_ff @(posedge clk) begin
        if (access && wr && in_range) begin
            mem[idx] <= w_merged;
            par[idx] <= ^w_merged;
        end
    end

    // Case equality keeps never-written (unknown) words from flagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            par_err <= 1'b0;
        end else if (access) begin
            par_err <= !wr && in_range && ((^{mem[idx], par[idx]}) === 1'b1);
            if (!wr) rd_data <= in_range ? mem[idx] : '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (access && wr && in_range) mem[idx] <= w_merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (access && !wr) begin
            rd_data <= in_range ? mem[idx] : '0;
        end
    end

    assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_param : handshaked data memory with wait states, byte lanes  |
// | and range/parity (DMEM_PARITY_EN) error reporting. Rev 1.0        |
// +------------------------------------------------------------------+
module dmem_param
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4112,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                ready,
    output logic                err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t              state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic                r_range_err;
    logic                w_access;
    logic                w_in_range;
    logic                w_par_err;

    assign w_access   = (state == WAIT) && (r_wcnt == '0);
    assign w_in_range = (r_addr < ADDR_W'(DEPTH));
    assign err        = r_range_err | w_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_wcnt      <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_range_err <= 1'b0;
            ready       <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        r_rw    <= rw;
                        r_addr  <= addr;
                        r_wdata <= wr_data;
                        r_be    <= byte_en;
                        r_wcnt  <= WCNT_W'(WAIT_STATES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end else begin
                        r_range_err <= !w_in_range;
                        ready       <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .access   (w_access),
        .wr       (r_rw),
        .in_range (w_in_range),
        .idx      (r_addr[IDX_W-1:0]),
        .wr_data  (r_wdata),
        .byte_en  (r_be),
        .rd_data  (rd_data),
        .par_err  (w_par_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_param : scoreboard bench, one 3-wait-state and one        |
// | zero-wait-state instance sharing clock and reset. Rev 1.0         |
// +------------------------------------------------------------------+
module tb_dmem_param;

    typedef struct {
        string       name;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid   [2];
    logic        rw      [2];
    logic [31:0] addr    [2];
    logic [31:0] wr_data [2];
    logic [3:0]  byte_en [2];
    logic [31:0] rd_data [2];
    logic        ready   [2];
    logic        err     [2];

    int   vecs = 0;
    int   miss = 0;
    int   cyc  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_param #(.DATA_W(32), .DEPTH(4112), .ADDR_W(32), .WAIT_STATES(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid(valid[0]), .rw(rw[0]), .addr(addr[0]),
        .wr_data(wr_data[0]), .byte_en(byte_en[0]), .rd_data(rd_data[0]),
        .ready(ready[0]), .err(err[0])
    );

    dmem_param #(.DATA_W(32), .DEPTH(4112), .ADDR_W(32), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid(valid[1]), .rw(rw[1]), .addr(addr[1]),
        .wr_data(wr_data[1]), .byte_en(byte_en[1]), .rd_data(rd_data[1]),
        .ready(ready[1]), .err(err[1])
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
        end
    endtask

    task automatic push(input int d, input string nm, input logic chk, input logic [31:0] rdv,
                        input logic e_err, input int ecyc);
        exp_t e;
        e.name = nm; e.chk_rd = chk; e.rd = rdv; e.err = e_err; e.cyc = ecyc;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ready(input int d, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = ready[d];
        end
        if (!seen) begin
            vecs++; miss++;
            $display("FAIL %s timeout: ready=0 after 30 cycles, expected ready=1", nm);
        end
    endtask

    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic chk, input logic [31:0] erd,
                         input logic e_err, input string nm);
        int ws = (d == 0) ? 3 : 0;
        @(negedge clk);
        valid[d] = 1'b1; rw[d] = w; addr[d] = a; wr_data[d] = wd; byte_en[d] = be;
        push(d, nm, chk, erd, e_err, cyc + 2 + ws);
        @(negedge clk);
        valid[d] = 1'b0;
        wait_ready(d, nm);
    endtask

    // Monitor: every ready pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (ready[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        vecs++; miss++;
                        $display("FAIL unexpected_ready dut%0d: ready=1, expected no pending request", d);
                    end else begin
                        if (d == 0) mon_e = q0.pop_front();
                        else        mon_e = q1.pop_front();
                        cmp({mon_e.name, " err"}, 32'(err[d]), 32'(mon_e.err));
                        cmp({mon_e.name, " ready_cycle"}, cyc, mon_e.cyc);
                        if (mon_e.chk_rd) cmp({mon_e.name, " rd_data"}, rd_data[d], mon_e.rd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; rw[d] = 1'b0; addr[d] = '0; wr_data[d] = '0; byte_en[d] = 4'hF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("reset rd_data dut%0d", d), rd_data[d], 32'h0);
            cmp($sformatf("reset ready dut%0d", d), 32'(ready[d]), 32'h0);
            cmp($sformatf("reset err dut%0d", d), 32'(err[d]), 32'h0);
        end

        // Back-to-back reads of 0..3 with valid held high; new addr set in DONE.
        @(negedge clk);
        valid[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'd0;
        push(1, "b2b addr0", 1'b0, 32'h0, 1'b0, cyc + 2);
        for (int k = 1; k < 4; k++) begin
            wait_ready(1, "b2b");
            addr[1] = k;
            push(1, $sformatf("b2b addr%0d", k), (k == 1), 32'h1, 1'b0, cyc + 3);
        end
        wait_ready(1, "b2b addr3");
        valid[1] = 1'b0;

        // Latency with 3 wait states; writes leave rd_data unchanged.
        issue(0, 1'b1, 32'd10, 32'h12345678, 4'hF, 1'b1, 32'h0,        1'b0, "wr10");
        issue(0, 1'b0, 32'd10, 32'h0,        4'hF, 1'b1, 32'h12345678, 1'b0, "rd10");
        issue(0, 1'b1, 32'd11, 32'h0,        4'hF, 1'b1, 32'h12345678, 1'b0, "wr11 hold");

        // Byte lanes.
        issue(0, 1'b1, 32'd20, 32'hFFFFFFFF, 4'hF,    1'b1, 32'h12345678, 1'b0, "wr20 full");
        issue(0, 1'b1, 32'd20, 32'h00000000, 4'b0101, 1'b1, 32'h12345678, 1'b0, "wr20 be0101");
        issue(0, 1'b0, 32'd20, 32'h0,        4'hF,    1'b1, 32'hFF00FF00, 1'b0, "rd20 merged");
        issue(0, 1'b1, 32'd20, 32'hCAFEF00D, 4'h0,    1'b1, 32'hFF00FF00, 1'b0, "wr20 be0");
        issue(0, 1'b0, 32'd20, 32'h0,        4'hF,    1'b1, 32'hFF00FF00, 1'b0, "rd20 after be0");

        // Range checks.
        issue(0, 1'b1, 32'd16,   32'h55AA55AA, 4'hF, 1'b1, 32'hFF00FF00, 1'b0, "wr16");
        issue(0, 1'b0, 32'd4112, 32'h0,        4'hF, 1'b1, 32'h0,        1'b1, "rd4112 oor");
        issue(0, 1'b1, 32'd4112, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b1, "wr4112 oor");
        issue(0, 1'b0, 32'd16,   32'h0,        4'hF, 1'b1, 32'h55AA55AA, 1'b0, "rd16 untouched");
        issue(0, 1'b0, 32'd4112, 32'h0,        4'hF, 1'b1, 32'h0,        1'b1, "rd4112 again");
        issue(0, 1'b0, 32'hFFFFFFFF, 32'h0,    4'hF, 1'b1, 32'h0,        1'b1, "rd max addr");

        // Reset during WAIT aborts a write.
        issue(0, 1'b1, 32'd5, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0, 1'b0, "wr5");
        @(negedge clk);
        valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'd5; wr_data[0] = 32'hDEADBEEF; byte_en[0] = 4'hF;
        @(negedge clk);
        valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ready[0]) seen = 1'b1;
        end
        cmp("abort no ready", 32'(seen), 32'h0);
        cmp("abort rd_data reset", rd_data[0], 32'h0);
        issue(0, 1'b0, 32'd5, 32'h0, 4'hF, 1'b1, 32'hA5A5A5A5, 1'b0, "rd5 after abort");

`ifdef DMEM_PARITY_EN
        issue(0, 1'b1, 32'd7, 32'h0F0F0F0F, 4'hF, 1'b1, 32'hA5A5A5A5, 1'b0, "wr7");
        @(negedge clk);
        dut0.u_array.mem[7][0] = ~dut0.u_array.mem[7][0];
        issue(0, 1'b0, 32'd7, 32'h0, 4'hF, 1'b1, 32'h0F0F0F0E, 1'b1, "rd7 parity");
`endif

        repeat (3) @(negedge clk);
        cmp("scoreboard drained", 32'(q0.size() + q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
`default_nettype wire
